// File: rtl/noc_pkg.sv
// Shared NoC flit layout, type encodings and widths.
// Also holds the data-flit parity helper used by receive-side endpoints.
package noc_pkg;

  localparam int unsigned TIME_SIZE      = 10;
  localparam int unsigned ID_SIZE        = 4;
  localparam int unsigned TOTAL_SIZE     = 40;
  localparam int unsigned TIME_SUM_SIZE  = 24;
  localparam int unsigned LOG_ROUTER_NUM = 4;

  localparam int unsigned SRC_MAX  = 39;
  localparam int unsigned SRC_MIN  = 36;
  localparam int unsigned DST_MAX  = 35;
  localparam int unsigned DST_MIN  = 32;
  localparam int unsigned TIME_MAX = 31;
  localparam int unsigned TIME_MIN = 22;
  localparam int unsigned DATA_MAX = 21;
  localparam int unsigned DATA_MIN = 2;
  localparam int unsigned TYPE_MAX = 1;
  localparam int unsigned TYPE_MIN = 0;

  localparam int unsigned DATA_SIZE     = DATA_MAX - DATA_MIN + 1;
  localparam int unsigned DBG_DATA_MAX  = 9;
  localparam int unsigned DBG_DATA_SIZE = DBG_DATA_MAX - DATA_MIN + 1;

  localparam logic [1:0] TYPE_DATA   = 2'b00;
  localparam logic [1:0] TYPE_RTXREQ = 2'b10;

  // The lowest DATA bit carries the XOR of the payload bits above it.
  function automatic logic parity_ok(input logic [TOTAL_SIZE-1:0] flit, input logic dbg);
    logic p;
    if (dbg) p = ^flit[DBG_DATA_MAX:DATA_MIN+1];
    else     p = ^flit[DATA_MAX:DATA_MIN+1];
    return p == flit[DATA_MIN];
  endfunction

endpackage

// File: rtl/noc_latency_stat.sv
// Latency accumulator: running min/max/sum and sample count.
// Updates one cycle after valid_i; clear_i restores reset values.
import noc_pkg::*;

module noc_latency_stat #(
  parameter int unsigned SumW = TIME_SUM_SIZE + LOG_ROUTER_NUM,
  parameter int unsigned CntW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 valid_i,
  input  logic [TIME_SIZE-1:0] lat_i,
  output logic [TIME_SIZE-1:0] min_o,
  output logic [TIME_SIZE-1:0] max_o,
  output logic [SumW-1:0]      sum_o,
  output logic [CntW-1:0]      cnt_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_o <= '1;
      max_o <= '0;
      sum_o <= '0;
      cnt_o <= '0;
    end else if (clear_i) begin
      min_o <= '1;
      max_o <= '0;
      sum_o <= '0;
      cnt_o <= '0;
    end else if (valid_i) begin
      if (lat_i < min_o) min_o <= lat_i;
      if (lat_i > max_o) max_o <= lat_i;
      sum_o <= sum_o + SumW'(lat_i);
      cnt_o <= cnt_o + CntW'(1);
    end
  end

endmodule

// File: rtl/noc_pe_receiver.sv
// NoC PE receive endpoint: sinks ejected flits, checks DST and parity, gathers
// latency statistics and issues retransmission requests for corrupted data flits.
import noc_pkg::*;

module noc_pe_receiver #(
  parameter logic [ID_SIZE-1:0] LOCAL_ID = 4'd0,
  parameter int unsigned        SUM_W    = TIME_SUM_SIZE + LOG_ROUTER_NUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  dbg_mode_i,
  input  logic [3:0]            receive_num_i,
  input  logic [TIME_SIZE-1:0]  cur_time_i,
  input  logic [TOTAL_SIZE-1:0] in_flit_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [TOTAL_SIZE-1:0] rtx_flit_o,
  output logic                  rtx_valid_o,
  input  logic                  rtx_ready_i,
  output logic                  task_receive_finish_flag_o,
  output logic [TIME_SIZE-1:0]  latency_min_o,
  output logic [TIME_SIZE-1:0]  latency_max_o,
  output logic [SUM_W-1:0]      latency_sum_o,
  output logic [3:0]            recv_cnt_o,
  output logic                  so_retrsreq_send_flag_o,
  output logic [7:0]            so_retrsreq_send_num_o,
  output logic                  dst_err_o
);

  typedef enum logic [1:0] {StIdle, StRun, StRtx, StDone} state_e;

  state_e                state_q;
  logic [TIME_SIZE-1:0]  lat_q;
  logic                  lat_vld_q;
  logic                  accept, run_accept, is_data, par_ok, good, bad, rtx_hs, reach;
  logic [4:0]            cnt_next;

  assign in_ready_o = ((state_q == StRun) && enable_i) || (state_q == StDone);
  assign accept     = in_valid_i && in_ready_o;
  assign run_accept = accept && (state_q == StRun);
  assign is_data    = in_flit_i[TYPE_MAX:TYPE_MIN] == TYPE_DATA;
  assign par_ok     = parity_ok(in_flit_i, dbg_mode_i);
  assign good       = run_accept && is_data && par_ok;
  assign bad        = run_accept && is_data && !par_ok;
  assign rtx_hs     = rtx_valid_o && rtx_ready_i;
  // Count as it will stand after this edge's stage-2 update; receive_num is compared live.
  assign cnt_next   = {1'b0, recv_cnt_o} + {4'd0, lat_vld_q};
  assign reach      = cnt_next >= {1'b0, receive_num_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                    <= StIdle;
      lat_q                      <= '0;
      lat_vld_q                  <= 1'b0;
      rtx_flit_o                 <= '0;
      rtx_valid_o                <= 1'b0;
      task_receive_finish_flag_o <= 1'b0;
      so_retrsreq_send_flag_o    <= 1'b0;
      so_retrsreq_send_num_o     <= '0;
      dst_err_o                  <= 1'b0;
    end else if (flush_i) begin
      state_q                    <= StIdle;
      lat_q                      <= '0;
      lat_vld_q                  <= 1'b0;
      rtx_flit_o                 <= '0;
      rtx_valid_o                <= 1'b0;
      task_receive_finish_flag_o <= 1'b0;
      so_retrsreq_send_flag_o    <= 1'b0;
      so_retrsreq_send_num_o     <= '0;
      dst_err_o                  <= 1'b0;
    end else begin
      lat_vld_q <= good;
      if (good) lat_q <= cur_time_i - in_flit_i[TIME_MAX:TIME_MIN];
      if (accept && (in_flit_i[DST_MAX:DST_MIN] != LOCAL_ID)) dst_err_o <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            if (receive_num_i == 4'd0) begin
              state_q                    <= StDone;
              task_receive_finish_flag_o <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (bad) begin
            state_q     <= StRtx;
            rtx_valid_o <= 1'b1;
            rtx_flit_o  <= {LOCAL_ID, in_flit_i[SRC_MAX:SRC_MIN], cur_time_i,
                            {DATA_SIZE{1'b0}}, TYPE_RTXREQ};
          end else if (reach) begin
            state_q                    <= StDone;
            task_receive_finish_flag_o <= 1'b1;
          end
        end
        StRtx: begin
          if (rtx_hs) begin
            state_q                 <= StRun;
            rtx_valid_o             <= 1'b0;
            so_retrsreq_send_flag_o <= 1'b1;
            if (so_retrsreq_send_num_o != 8'hFF) begin
              so_retrsreq_send_num_o <= so_retrsreq_send_num_o + 8'd1;
            end
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  noc_latency_stat #(
    .SumW (SUM_W),
    .CntW (4)
  ) u_stat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush_i),
    .valid_i (lat_vld_q),
    .lat_i   (lat_q),
    .min_o   (latency_min_o),
    .max_o   (latency_max_o),
    .sum_o   (latency_sum_o),
    .cnt_o   (recv_cnt_o)
  );

endmodule

// File: tb/tb_noc_pe_receiver.sv
// Directed self-checking bench for noc_pe_receiver (LOCAL_ID=4).
`timescale 1ns/1ps
module tb_noc_pe_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, flush, dbg_mode, in_valid, in_ready, rtx_valid, rtx_ready;
  logic [3:0]  receive_num, recv_cnt;
  logic [9:0]  cur_time, lat_min, lat_max;
  logic [39:0] in_flit, rtx_flit;
  logic        finish_flag, rq_flag, dst_err;
  logic [27:0] lat_sum;
  logic [7:0]  rq_num;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_pe_receiver #(
    .LOCAL_ID (4'd4),
    .SUM_W    (28)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .enable_i                   (enable),
    .flush_i                    (flush),
    .dbg_mode_i                 (dbg_mode),
    .receive_num_i              (receive_num),
    .cur_time_i                 (cur_time),
    .in_flit_i                  (in_flit),
    .in_valid_i                 (in_valid),
    .in_ready_o                 (in_ready),
    .rtx_flit_o                 (rtx_flit),
    .rtx_valid_o                (rtx_valid),
    .rtx_ready_i                (rtx_ready),
    .task_receive_finish_flag_o (finish_flag),
    .latency_min_o              (lat_min),
    .latency_max_o              (lat_max),
    .latency_sum_o              (lat_sum),
    .recv_cnt_o                 (recv_cnt),
    .so_retrsreq_send_flag_o    (rq_flag),
    .so_retrsreq_send_num_o     (rq_num),
    .dst_err_o                  (dst_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [39:0] mk(input logic [3:0] src, input logic [3:0] dst,
                                     input logic [9:0] t, input logic [19:0] d,
                                     input logic [1:0] ty);
    return {src, dst, t, d, ty};
  endfunction

  function automatic logic [39:0] good(input logic [3:0] src, input logic [3:0] dst,
                                       input logic [9:0] t, input logic [18:0] p);
    return mk(src, dst, t, {p, ^p}, 2'b00);
  endfunction

  function automatic logic [39:0] bad(input logic [3:0] src, input logic [3:0] dst,
                                      input logic [9:0] t, input logic [18:0] p);
    return mk(src, dst, t, {p, ~^p}, 2'b00);
  endfunction

  // Present a flit and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [39:0] f);
    int waited = 0;
    in_flit  = f;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      tick(1);
      waited++;
    end
    if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
    else tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_in_ready"},  {63'd0, in_ready},    64'd0);
    check({p, "_rtx_valid"}, {63'd0, rtx_valid},   64'd0);
    check({p, "_rtx_flit"},  {24'd0, rtx_flit},    64'd0);
    check({p, "_finish"},    {63'd0, finish_flag}, 64'd0);
    check({p, "_lat_min"},   {54'd0, lat_min},     64'h3FF);
    check({p, "_lat_max"},   {54'd0, lat_max},     64'd0);
    check({p, "_lat_sum"},   {36'd0, lat_sum},     64'd0);
    check({p, "_recv_cnt"},  {60'd0, recv_cnt},    64'd0);
    check({p, "_rq_flag"},   {63'd0, rq_flag},     64'd0);
    check({p, "_rq_num"},    {56'd0, rq_num},      64'd0);
    check({p, "_dst_err"},   {63'd0, dst_err},     64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; dbg_mode = 1'b0; in_valid = 1'b0;
    rtx_ready = 1'b0; receive_num = 4'd0; cur_time = 10'd0; in_flit = '0;
    tick(2);
    check_reset("reset");
    rst_n = 1'b1;

    // Two good flits: latencies 5 and 20
    receive_num = 4'd2;
    enable = 1'b1;
    tick(1);
    check("run_in_ready", {63'd0, in_ready}, 64'd1);
    cur_time = 10'd15;
    send(good(4'd1, 4'd4, 10'd10, 19'h1234));
    cur_time = 10'd40;
    send(good(4'd2, 4'd4, 10'd20, 19'h0F0F));
    tick(2);
    check("t1_min",    {54'd0, lat_min},     64'd5);
    check("t1_max",    {54'd0, lat_max},     64'd20);
    check("t1_sum",    {36'd0, lat_sum},     64'd25);
    check("t1_cnt",    {60'd0, recv_cnt},    64'd2);
    check("t1_finish", {63'd0, finish_flag}, 64'd1);
    check("t1_dst",    {63'd0, dst_err},     64'd0);
    check("done_rdy",  {63'd0, in_ready},    64'd1);
    send(good(4'd1, 4'd4, 10'd0, 19'h0001));
    tick(2);
    check("done_cnt",  {60'd0, recv_cnt},    64'd2);
    check("done_sum",  {36'd0, lat_sum},     64'd25);

    // Non-data flit ignored; timestamp wrap 1020 -> 4 gives 8
    do_flush();
    check_reset("flush1");
    receive_num = 4'd1;
    tick(1);
    send(mk(4'd1, 4'd4, 10'd0, 20'h00001, 2'b01));
    cur_time = 10'd4;
    send(good(4'd1, 4'd4, 10'd1020, 19'h00055));
    tick(2);
    check("wrap_min",    {54'd0, lat_min},     64'd8);
    check("wrap_max",    {54'd0, lat_max},     64'd8);
    check("wrap_sum",    {36'd0, lat_sum},     64'd8);
    check("wrap_cnt",    {60'd0, recv_cnt},    64'd1);
    check("wrap_finish", {63'd0, finish_flag}, 64'd1);

    // Parity error from SRC=7 at time 100, request stalled 3 cycles
    do_flush();
    receive_num = 4'd3;
    tick(1);
    cur_time = 10'd100;
    send(bad(4'd7, 4'd4, 10'd50, 19'h00011));
    cur_time = 10'd101;
    for (int i = 0; i < 3; i++) begin
      check("rtx_valid_hold", {63'd0, rtx_valid}, 64'd1);
      check("rtx_flit_hold",  {24'd0, rtx_flit},
            {24'd0, 4'd4, 4'd7, 10'd100, 20'd0, 2'b10});
      check("rtx_in_ready",   {63'd0, in_ready},  64'd0);
      tick(1);
    end
    rtx_ready = 1'b1;
    tick(1);
    rtx_ready = 1'b0;
    check("rtx_valid_done", {63'd0, rtx_valid}, 64'd0);
    check("rtx_num",        {56'd0, rq_num},    64'd1);
    check("rtx_flag",       {63'd0, rq_flag},   64'd1);
    check("rtx_cnt",        {60'd0, recv_cnt},  64'd0);
    check("rtx_back_run",   {63'd0, in_ready},  64'd1);

    // Debug payload: upper bits would break full-width parity, low byte is correct
    dbg_mode = 1'b1;
    cur_time = 10'd200;
    send(mk(4'd2, 4'd4, 10'd150, 20'hABC06, 2'b00));
    tick(2);
    dbg_mode = 1'b0;
    check("dbg_cnt", {60'd0, recv_cnt}, 64'd1);
    check("dbg_min", {54'd0, lat_min},  64'd50);
    check("dbg_sum", {36'd0, lat_sum},  64'd50);

    // receive_num=0 finishes at once; misrouted flit flags dst_err only
    do_flush();
    receive_num = 4'd0;
    tick(2);
    check("rn0_finish", {63'd0, finish_flag}, 64'd1);
    cur_time = 10'd5;
    send(good(4'd1, 4'd3, 10'd0, 19'h00300));
    tick(2);
    check("rn0_dst_err", {63'd0, dst_err},  64'd1);
    check("rn0_cnt",     {60'd0, recv_cnt}, 64'd0);
    check("rn0_max",     {54'd0, lat_max},  64'd0);

    // Flush beats a simultaneous handshake and an offered flit
    do_flush();
    receive_num = 4'd5;
    tick(1);
    cur_time = 10'd300;
    send(bad(4'd9, 4'd4, 10'd290, 19'h00700));
    check("fr_rtx_pend", {63'd0, rtx_valid}, 64'd1);
    flush = 1'b1; rtx_ready = 1'b1; in_valid = 1'b1;
    in_flit = good(4'd1, 4'd4, 10'd299, 19'h00123);
    enable = 1'b0;
    tick(1);
    flush = 1'b0; rtx_ready = 1'b0; in_valid = 1'b0;
    check_reset("flush_rtx");
    enable = 1'b1;
    tick(2);
    check("fr_cnt_after", {60'd0, recv_cnt}, 64'd0);

    // Request counter saturation
    receive_num = 4'd15;
    rtx_ready = 1'b1;
    for (int i = 0; i < 60; i++) send(bad(4'd3, 4'd4, 10'd0, 19'h00001));
    tick(1);
    check("sat_60", {56'd0, rq_num}, 64'd60);
    for (int i = 0; i < 200; i++) send(bad(4'd3, 4'd4, 10'd0, 19'h00001));
    tick(1);
    rtx_ready = 1'b0;
    check("sat_255",  {56'd0, rq_num},   64'd255);
    check("sat_flag", {63'd0, rq_flag},  64'd1);
    check("sat_cnt",  {60'd0, recv_cnt}, 64'd0);

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    check("async_rq_num", {56'd0, rq_num},  64'd0);
    check("async_rdy",    {63'd0, in_ready}, 64'd0);
    tick(1);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
